pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, payload width (PC, PC+4, Instr packed).
REQ-002 SHALL have parameter NOP_VALUE, DATA_W bits, default all-zero, the bubble payload shown when out_valid=0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-006 SHALL have port in_ready, output, 1, stage accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-008 SHALL have port flush, input, 1, synchronous kill of all held entries.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a live entry.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-011 SHALL have port out_data, output, DATA_W, head entry payload, or NOP_VALUE when out_valid=0.
REQ-012 SHALL have port occupancy, output, 2, count of live entries (0..2).

Function
REQ-013 SHALL treat input transfer as in_valid & in_ready and output transfer as out_valid & out_ready, both sampled on the clk rising edge.
REQ-014 SHALL have latency exactly 1 cycle: an entry accepted on edge N is presented on out_data after edge N.
REQ-015 SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-016 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0 (no payload change, no drop).
REQ-017 SHALL drive out_data = NOP_VALUE whenever out_valid=0.
REQ-018 SHALL force in_ready=0 while flush=1; a flush cycle accepts nothing.
REQ-019 SHALL, on an edge with flush=1, clear all valid bits, set occupancy=0, set out_data=NOP_VALUE, regardless of out_ready or in_valid.
REQ-020 SHALL NOT count an output transfer in the flush cycle as a loss; the downstream consumes it if out_ready=1, the stage empties anyway.
REQ-021 SHALL preserve entry order; no reordering, duplication or loss outside flush/reset.
REQ-022 SHALL keep occupancy equal to the number of valid bits set, updated on the same edge as each transfer.
REQ-023 SHALL ignore in_data when in_valid=0; no state change from in_data alone.

Reset
REQ-024 SHALL, while reset=1, asynchronously force out_valid=0, occupancy=0, out_data=NOP_VALUE, all internal valid bits=0.
REQ-025 SHALL drive in_ready=0 while reset=1, and in_ready=1 on the first cycle after reset deasserts with flush=0.
REQ-026 SHALL discard any in-flight entry on reset assertion mid-operation, with no partial update after release.

Configuration
REQ-027 SHALL compile a second skid entry when macro PIPE_STAGE_SKID_EN is defined.
REQ-028 SHALL, with PIPE_STAGE_SKID_EN defined, drive in_ready = !skid_valid & !flush from registered state only (no combinational path from out_ready to in_ready); accept into the skid entry when the head is full and out_ready=0; promote skid to head on head output transfer; occupancy range 0..2.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN undefined, hold one entry only, drive in_ready = (!out_valid | out_ready) & !flush combinationally, occupancy range 0..1, bit 1 tied 0.

Verification
REQ-030 SHALL cover: reset=1 with in_valid=1, in_data=0x100_104_12345678 -> out_valid=0, out_data=0, occupancy=0; release, one more edge -> out_data=0x100_104_12345678, out_valid=1.
REQ-031 SHALL cover: stream 0x1,0x2,0x3 at out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, one-cycle latency, no bubbles.
REQ-032 SHALL cover (skid build): head=0xA, out_ready=0, offer 0xB then 0xC -> 0xB accepted (occupancy=2), in_ready=0, 0xC held upstream; out_ready=1 -> 0xA, 0xB, 0xC in order.
REQ-033 SHALL cover: occupancy=2, flush=1 with in_valid=1, in_data=0xDEADBEEF -> in_ready=0, next edge out_valid=0, out_data=NOP_VALUE, occupancy=0, 0xDEADBEEF never appears.
REQ-034 SHALL cover (non-skid build): head=0x500, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, 0x504 accepted and presented next cycle.
REQ-035 SHALL cover: reset asserted asynchronously mid-cycle with occupancy=1 -> out_valid drops before next clk edge, out_data=NOP_VALUE.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register stage with flush.
//
// Carries one packed payload (PC, PC+4, Instr by default) from an upstream
// producer to a downstream consumer with exactly one cycle of latency.
// Empty slots present NOP_VALUE on out_data so a bubble looks like a NOP.
//
// Build option:
//   PIPE_STAGE_SKID_EN  - when defined, a second (skid) entry is compiled in
//                         and in_ready is derived from registered state only,
//                         which breaks the out_ready -> in_ready timing path.
//                         When undefined, the stage holds a single entry and
//                         in_ready looks straight through at out_ready.
//
// Reset is asynchronous and active-high; flush is synchronous and empties
// every held entry on the edge where it is sampled high.

module pipe_stage_reg #(
  parameter int                DATA_W    = 96,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Head entry: the one currently presented downstream.
  logic              r_head_valid;
  logic [DATA_W-1:0] r_head_data;

  // Handshake qualifiers for this cycle.
  logic w_in_xfer;
  logic w_out_xfer;

  // Next-state values for the head entry.
  logic              w_head_valid_next;
  logic [DATA_W-1:0] w_head_data_next;

  assign out_valid  = r_head_valid;
  assign w_out_xfer = r_head_valid & out_ready;
  assign w_in_xfer  = in_valid & in_ready;

  // A bubble always shows the NOP payload, never stale head data.
  assign out_data = r_head_valid ? r_head_data : NOP_VALUE;

`ifdef PIPE_STAGE_SKID_EN

  // Skid entry: catches the one beat accepted while the head is stalled.
  // It is only ever valid while the head is valid as well.
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_skid_valid_next;
  logic [DATA_W-1:0] w_skid_data_next;

  // Head slot is free after this edge: empty now, or draining this cycle.
  logic w_head_free;

  assign w_head_free = ~r_head_valid | w_out_xfer;

  // Ready comes only from registers (plus reset/flush), never from out_ready.
  assign in_ready = ~r_skid_valid & ~flush & ~reset;

  // Valid bits: head and skid; skid implies head, so this is the count.
  assign occupancy = {r_head_valid & r_skid_valid, r_head_valid ^ r_skid_valid};

  // Next-state: refill the head from skid first, then from upstream; park
  // an upstream beat in the skid entry when the head is held.
  always_comb begin
    w_head_valid_next = r_head_valid;
    w_head_data_next  = r_head_data;
    w_skid_valid_next = r_skid_valid;
    w_skid_data_next  = r_skid_data;

    if (flush) begin
      w_head_valid_next = 1'b0;
      w_head_data_next  = NOP_VALUE;
      w_skid_valid_next = 1'b0;
      w_skid_data_next  = NOP_VALUE;
    end else if (w_head_free) begin
      if (r_skid_valid) begin
        // in_ready was low, so no upstream beat competes with the promotion.
        w_head_valid_next = 1'b1;
        w_head_data_next  = r_skid_data;
        w_skid_valid_next = 1'b0;
      end else if (w_in_xfer) begin
        w_head_valid_next = 1'b1;
        w_head_data_next  = in_data;
      end else begin
        w_head_valid_next = 1'b0;
      end
    end else if (w_in_xfer) begin
      // Head is full and stalled; the new beat waits behind it.
      w_skid_valid_next = 1'b1;
      w_skid_data_next  = in_data;
    end
  end

  // Skid entry register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= NOP_VALUE;
    end else begin
      r_skid_valid <= w_skid_valid_next;
      r_skid_data  <= w_skid_data_next;
    end
  end

`else

  // Single entry: accept when the head is empty or leaves this same edge.
  assign in_ready = (~r_head_valid | out_ready) & ~flush & ~reset;

  // Only one valid bit exists, so the upper occupancy bit is constant.
  assign occupancy = {1'b0, r_head_valid};

  // Next-state: load on input transfer, empty on a lone output transfer.
  always_comb begin
    w_head_valid_next = r_head_valid;
    w_head_data_next  = r_head_data;

    if (flush) begin
      w_head_valid_next = 1'b0;
      w_head_data_next  = NOP_VALUE;
    end else if (w_in_xfer) begin
      w_head_valid_next = 1'b1;
      w_head_data_next  = in_data;
    end else if (w_out_xfer) begin
      w_head_valid_next = 1'b0;
    end
  end

`endif

  // Head entry register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_valid <= 1'b0;
      r_head_data  <= NOP_VALUE;
    end else begin
      r_head_valid <= w_head_valid_next;
      r_head_data  <= w_head_data_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- directed bench for pipe_stage_reg.
// Stimulus pushes expected payloads into a queue when an input transfer is
// seen; a separate monitor pops and compares on every output transfer.
// Works for both the default and PIPE_STAGE_SKID_EN builds.

module tb_pipe_stage_reg;

  localparam int          W   = 96;
  localparam logic [W-1:0] NOP = '0;
  localparam logic [W-1:0] RST_WORD = 96'h00000100_00000104_12345678;
  localparam logic [W-1:0] DEAD     = 96'h00000000_00000000_DEADBEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] expq[$];
  logic [W-1:0] m_exp;

  // Values sampled at the negedge inside each driven cycle.
  logic         s_in_ready;
  logic         s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occ;

  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_occ       = occupancy;
    if (v && in_ready) begin
      expq.push_back(d);
      $display("in  %h", d);
    end
    @(posedge clk);
    #1;
    if (fl) expq.delete();
  endtask

  // Monitor: every output transfer must match the oldest expected payload.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          m_exp = expq.pop_front();
          $display("out %h", out_data);
          check("scoreboard", out_data, m_exp);
        end
      end
      if (!out_valid) check("nop_when_idle", out_data, NOP);
    end
  end

  // Watchdog bounds the whole run.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int idx;
  int cyc;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = RST_WORD;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset held with a valid input offered: nothing may be captured.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, NOP);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    drive(1'b1, RST_WORD, 1'b1, 1'b0);
    check("post_rst_in_ready", s_in_ready, 1'b1);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("post_rst_valid", s_out_valid, 1'b1);
    check("post_rst_data", s_out_data, RST_WORD);

    // Back-to-back stream at out_ready=1: one-cycle latency, no bubbles.
    drive(1'b1, 96'h1, 1'b1, 1'b0);
    drive(1'b1, 96'h2, 1'b1, 1'b0);
    check("stream_0", s_out_data, 96'h1);
    drive(1'b1, 96'h3, 1'b1, 1'b0);
    check("stream_1", s_out_data, 96'h2);
    check("stream_1_ready", s_in_ready, 1'b1);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("stream_2", s_out_data, 96'h3);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("stream_empty_valid", s_out_valid, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
    // Skid capture: A in head, B parks in skid, C held upstream.
    drive(1'b1, 96'hA, 1'b1, 1'b0);
    drive(1'b1, 96'hB, 1'b0, 1'b0);
    check("skid_b_ready", s_in_ready, 1'b1);
    check("skid_occ1", s_occ, 2'd1);
    drive(1'b1, 96'hC, 1'b0, 1'b0);
    check("skid_c_blocked", s_in_ready, 1'b0);
    check("skid_occ2", s_occ, 2'd2);
    check("skid_head_a", s_out_data, 96'hA);
    drive(1'b1, 96'hC, 1'b1, 1'b0);
    check("skid_drain_blocked", s_in_ready, 1'b0);
    drive(1'b1, 96'hC, 1'b1, 1'b0);
    check("skid_head_b", s_out_data, 96'hB);
    check("skid_c_ready", s_in_ready, 1'b1);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("skid_head_c", s_out_data, 96'hC);
`else
    // Single entry: in_ready follows out_ready in the same cycle.
    drive(1'b1, 96'h500, 1'b1, 1'b0);
    drive(1'b1, 96'h504, 1'b0, 1'b0);
    check("stall_in_ready", s_in_ready, 1'b0);
    check("stall_head", s_out_data, 96'h500);
    drive(1'b1, 96'h504, 1'b1, 1'b0);
    check("release_in_ready", s_in_ready, 1'b1);
    check("release_head", s_out_data, 96'h500);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("next_head", s_out_data, 96'h504);
`endif
    drive(1'b0, NOP, 1'b1, 1'b0);

    // Mixed backpressure; a beat is re-offered until it is accepted.
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 40) begin
      drive(1'b1, 96'h2000 + W'(idx), ((cyc % 3) != 0), 1'b0);
      if (s_in_ready) idx++;
      cyc++;
    end
    check("bp_accepted", W'(idx), W'(6));
    repeat (4) drive(1'b0, NOP, 1'b1, 1'b0);
    check("bp_drained", W'(expq.size()), W'(0));

    // Flush with held entries and a valid offer: nothing survives.
    drive(1'b1, 96'h70, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 96'h71, 1'b0, 1'b0);
    drive(1'b1, DEAD, 1'b0, 1'b1);
    check("flush_occ_before", s_occ, 2'd2);
`else
    drive(1'b1, DEAD, 1'b0, 1'b1);
    check("flush_occ_before", s_occ, 2'd1);
`endif
    check("flush_in_ready", s_in_ready, 1'b0);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("flush_valid", s_out_valid, 1'b0);
    check("flush_data", s_out_data, NOP);
    check("flush_occ", s_occ, 2'd0);
    drive(1'b0, NOP, 1'b1, 1'b0);

    // Flush while the head leaves: consumed downstream, stage still empties.
    drive(1'b1, 96'h80, 1'b1, 1'b0);
    drive(1'b0, NOP, 1'b1, 1'b1);
    check("flush_xfer_valid", s_out_valid, 1'b1);
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("flush_xfer_empty", s_out_valid, 1'b0);

    // Asynchronous reset mid-cycle with one entry held.
    drive(1'b1, 96'h90, 1'b0, 1'b0);
    check("pre_areset_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("areset_valid", out_valid, 1'b0);
    check("areset_data", out_data, NOP);
    check("areset_occ", occupancy, 2'd0);
    check("areset_in_ready", in_ready, 1'b0);
    expq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, NOP, 1'b1, 1'b0);
    check("post_areset_valid", s_out_valid, 1'b0);
    check("post_areset_ready", s_in_ready, 1'b1);
    check("post_areset_occ", s_occ, 2'd0);

    check("final_queue_empty", W'(expq.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
